// File: rtl/somador_arb_pkg.sv
// Shared types and helpers for the round-robin front end of the shared signed adder.
package somador_arb_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Signed overflow from sign bits: operands agree in sign, sum does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/somador.sv
// Combinational signed adder shared by all requesters; sum wraps modulo 2^WIDTH.
module Somador #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] Entrada1,
    input  logic [WIDTH-1:0] Entrada2,
    output logic [WIDTH-1:0] Resultado
);

    assign Resultado = Entrada1 + Entrada2;

endmodule

// File: rtl/somador_arbitro_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, searching cyclically.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/somador_arbitro.sv
// Time-shares one external adder among NUM_REQ requesters; one transaction in flight,
// responses tagged with the requester index over a valid/ready handshake.
module somador_arbitro
    import somador_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = somador_arb_pkg::WIDTH,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         Entrada1,
    output logic [WIDTH-1:0]         Entrada2,
    input  logic [WIDTH-1:0]         Resultado,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_overflow,
    output logic                     busy
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  e1_q, e1_d;
    logic [WIDTH-1:0]  e2_q, e2_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_ovf_q, rsp_ovf_d;

    logic [NUM_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               grant_en;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    // Resetn in the term keeps req_ready low while reset is held.
    assign grant_en = (state_q == IDLE) && gnt_any && Resetn;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_en) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = grant_en ? gnt_onehot : '0;
        busy      = (state_q != IDLE);
    end

    always_comb begin
        ptr_d        = ptr_q;
        id_d         = id_q;
        e1_d         = e1_q;
        e2_d         = e2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_ovf_d    = rsp_ovf_q;
        if (grant_en) begin
            e1_d  = req_a[gnt_idx*WIDTH +: WIDTH];
            e2_d  = req_b[gnt_idx*WIDTH +: WIDTH];
            id_d  = gnt_idx;
            ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
        if (state_q == CALC) begin
            rsp_result_d = Resultado;
            rsp_id_d     = id_q;
            rsp_ovf_d    = add_ovf(e1_q[WIDTH-1], e2_q[WIDTH-1], Resultado[WIDTH-1]);
            rsp_valid_d  = 1'b1;
        end
        if (state_q == RESP && rsp_ready) rsp_valid_d = 1'b0;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ptr_q        <= '0;
            id_q         <= '0;
            e1_q         <= '0;
            e2_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            e1_q         <= e1_d;
            e2_q         <= e2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    assign Entrada1     = e1_q;
    assign Entrada2     = e2_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_ovf_q;

endmodule

// File: tb/tb_somador_arbitro.sv
// Bench for somador_arbitro wired to a Somador instance; scoreboard fed at each grant.
module tb_somador_arbitro;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_ready;
    logic [7:0]  Entrada1, Entrada2, Resultado;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_result;
    logic        rsp_overflow;
    logic        busy;

    typedef struct {
        logic [1:0] id;
        logic [7:0] res;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   grant_idx_q[$];
    int   grant_cyc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   rsp_cnt = 0;

    Somador #(.WIDTH(8)) u_add (
        .Entrada1  (Entrada1),
        .Entrada2  (Entrada2),
        .Resultado (Resultado)
    );

    somador_arbitro #(.NUM_REQ(4), .WIDTH(8)) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .Entrada1     (Entrada1),
        .Entrada2     (Entrada2),
        .Resultado    (Resultado),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    // Grant and response monitor: push the model result on each grant, pop on each handshake.
    always @(negedge Clock) begin
        exp_t e;
        int g, s;
        logic [7:0] a, b;
        if (Resetn === 1'b1) begin
            if (req_ready !== 4'b0000) begin
                checks++;
                if ($countones(req_ready) != 1) begin
                    errors++;
                    $display("FAIL req_ready_onehot got %b", req_ready);
                end
                g = 0;
                for (int k = 0; k < 4; k++) if (req_ready[k]) g = k;
                a = req_a[g*8 +: 8];
                b = req_b[g*8 +: 8];
                s = int'($signed(a)) + int'($signed(b));
                e.id  = 2'(g);
                e.res = 8'(s);
                e.ovf = (s > 127) || (s < -128);
                exp_q.push_back(e);
                grant_idx_q.push_back(g);
                grant_cyc_q.push_back(cyc);
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                hs_cyc = cyc;
                rsp_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected id=%0d result=%h", rsp_id, rsp_result);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_id, rsp_result, rsp_overflow} !== {e.id, e.res, e.ovf}) begin
                        errors++;
                        $display("FAIL rsp_scoreboard got id=%0d res=%h ovf=%b want id=%0d res=%h ovf=%b",
                                 rsp_id, rsp_result, rsp_overflow, e.id, e.res, e.ovf);
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge Clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        Resetn = 1'b0;
        req_valid = 4'b1111;
        req_a = 32'h1234_5678;
        req_b = 32'h9abc_def0;
        repeat (2) @(negedge Clock);
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_valid_busy got %b%b want 00", rsp_valid, busy);
        end
        checks++;
        if (Entrada1 !== 8'h00 || Entrada2 !== 8'h00) begin
            errors++; $display("FAIL reset_operands got %h %h want 00 00", Entrada1, Entrada2);
        end
        checks++;
        if ({rsp_id, rsp_result, rsp_overflow} !== 11'd0) begin
            errors++; $display("FAIL reset_rsp got %h want 0", {rsp_id, rsp_result, rsp_overflow});
        end
        req_valid = 4'b0000;
        @(posedge Clock); #1;
        Resetn = 1'b1;
    endtask

    task automatic test_single;
        rsp_ready = 1'b0;
        @(posedge Clock); #1;
        set_req(2, 8'd5, 8'd3);
        req_valid = 4'b0100;
        @(negedge Clock);
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", req_ready); end
        @(posedge Clock); #1;
        req_valid = 4'b0000;
        @(negedge Clock);
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b1 || Entrada1 !== 8'd5 || Entrada2 !== 8'd3) begin
            errors++;
            $display("FAIL single_calc got rdy=%b v=%b busy=%b e1=%h e2=%h want 0000 0 1 05 03",
                     req_ready, rsp_valid, busy, Entrada1, Entrada2);
        end
        @(negedge Clock);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 8'd8 || rsp_overflow !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp got v=%b id=%0d res=%h ovf=%b want 1 2 08 0",
                     rsp_valid, rsp_id, rsp_result, rsp_overflow);
        end
        @(posedge Clock); #1;
        rsp_ready = 1'b1;
        @(posedge Clock); #1;
        rsp_ready = 1'b0;
        @(negedge Clock);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || Entrada1 !== 8'd5 || Entrada2 !== 8'd3) begin
            errors++;
            $display("FAIL single_done got v=%b busy=%b e1=%h e2=%h want 0 0 05 03", rsp_valid, busy, Entrada1, Entrada2);
        end
        wait_drain("single");
    endtask

    task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b,
                          output logic [1:0] id, output logic [7:0] res, output logic ovf);
        int n = 0;
        @(posedge Clock); #1;
        set_req(i, a, b);
        req_valid[i] = 1'b1;
        @(negedge Clock);
        while (req_ready[i] !== 1'b1 && n < 10) begin @(negedge Clock); n++; end
        if (n >= 10) begin checks++; errors++; $display("FAIL op_grant_timeout req=%0d", i); end
        @(posedge Clock); #1;
        req_valid[i] = 1'b0;
        n = 0;
        @(negedge Clock);
        while (rsp_valid !== 1'b1 && n < 10) begin @(negedge Clock); n++; end
        if (n >= 10) begin checks++; errors++; $display("FAIL op_rsp_timeout req=%0d", i); end
        id = rsp_id; res = rsp_result; ovf = rsp_overflow;
        @(posedge Clock); #1;
        rsp_ready = 1'b1;
        @(posedge Clock); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_overflow;
        logic [1:0] id;
        logic [7:0] res;
        logic       ovf;
        run_op(3, 8'd100, 8'd100, id, res, ovf);
        checks++;
        if ({id, res, ovf} !== {2'd3, 8'hC8, 1'b1}) begin
            errors++; $display("FAIL ovf_pos got id=%0d res=%h ovf=%b want 3 c8 1", id, res, ovf);
        end
        run_op(0, 8'h80, 8'hFF, id, res, ovf);
        checks++;
        if ({id, res, ovf} !== {2'd0, 8'h7F, 1'b1}) begin
            errors++; $display("FAIL ovf_neg got id=%0d res=%h ovf=%b want 0 7f 1", id, res, ovf);
        end
        run_op(3, 8'hFD, 8'h02, id, res, ovf);
        checks++;
        if ({id, res, ovf} !== {2'd3, 8'hFF, 1'b0}) begin
            errors++; $display("FAIL ovf_none got id=%0d res=%h ovf=%b want 3 ff 0", id, res, ovf);
        end
        wait_drain("overflow");
    endtask

    task automatic test_round_robin;
        int n = 0;
        grant_idx_q.delete();
        grant_cyc_q.delete();
        for (int i = 0; i < 4; i++) set_req(i, 8'(10 * i + 1), 8'(i - 7));
        @(posedge Clock); #1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        while (grant_idx_q.size() < 5 && n < 40) begin @(posedge Clock); #1; n++; end
        req_valid = 4'b0000;
        checks++;
        if (grant_idx_q.size() < 5) begin
            errors++; $display("FAIL rr_timeout grants=%0d want 5", grant_idx_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (grant_idx_q[k] != (k % 4)) begin
                    errors++; $display("FAIL rr_order[%0d] got %0d want %0d", k, grant_idx_q[k], k % 4);
                end
            end
            for (int k = 1; k < 5; k++) begin
                checks++;
                if (grant_cyc_q[k] - grant_cyc_q[k-1] != 3) begin
                    errors++; $display("FAIL rr_spacing[%0d] got %0d want 3", k, grant_cyc_q[k] - grant_cyc_q[k-1]);
                end
            end
        end
        wait_drain("rr");
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [10:0] r0;
        int n = 0;
        int gc;
        rsp_ready = 1'b0;
        @(posedge Clock); #1;
        set_req(1, 8'd20, 8'd22);
        set_req(2, 8'd7, 8'hF7);
        req_valid = 4'b0110;
        @(negedge Clock);
        while (req_ready === 4'b0000 && n < 10) begin @(negedge Clock); n++; end
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant got %b want 0010", req_ready); end
        @(posedge Clock); #1;
        req_valid[1] = 1'b0;
        n = 0;
        @(negedge Clock);
        while (rsp_valid !== 1'b1 && n < 10) begin @(negedge Clock); n++; end
        r0 = {rsp_id, rsp_result, rsp_overflow};
        checks++;
        if (r0 !== {2'd1, 8'd42, 1'b0}) begin errors++; $display("FAIL bp_rsp got %h want %h", r0, {2'd1, 8'd42, 1'b0}); end
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            checks++;
            if (rsp_valid !== 1'b1 || {rsp_id, rsp_result, rsp_overflow} !== r0 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b rsp=%h rdy=%b want 1 %h 0000",
                         k, rsp_valid, {rsp_id, rsp_result, rsp_overflow}, req_ready, r0);
            end
        end
        gc = grant_cyc_q.size();
        @(posedge Clock); #1;
        rsp_ready = 1'b1;
        @(posedge Clock); #1;
        rsp_ready = 1'b0;
        n = 0;
        while (grant_cyc_q.size() == gc && n < 10) begin @(negedge Clock); n++; end
        checks++;
        if (grant_cyc_q.size() == gc) begin
            errors++; $display("FAIL bp_next_grant_timeout");
        end else if (grant_idx_q[$] != 2 || grant_cyc_q[$] != hs_cyc + 1) begin
            errors++;
            $display("FAIL bp_next_grant got idx=%0d at +%0d want idx=2 at +1", grant_idx_q[$], grant_cyc_q[$] - hs_cyc);
        end
        @(posedge Clock); #1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        wait_drain("bp");
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int rc;
        int gc;
        @(posedge Clock); #1;
        set_req(1, 8'd50, 8'd60);
        req_valid = 4'b0010;
        @(negedge Clock);
        while (req_ready[1] !== 1'b1 && n < 10) begin @(negedge Clock); n++; end
        @(posedge Clock); #1;
        Resetn = 1'b0;
        req_valid = 4'b0000;
        exp_q.delete();
        rc = rsp_cnt;
        repeat (3) begin
            @(negedge Clock);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || Entrada1 !== 8'h00) begin
                errors++;
                $display("FAIL midrst_hold got v=%b busy=%b e1=%h want 0 0 00", rsp_valid, busy, Entrada1);
            end
        end
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'(i + 2));
        gc = grant_idx_q.size();
        @(posedge Clock); #1;
        Resetn = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        n = 0;
        while (grant_idx_q.size() == gc && n < 10) begin @(negedge Clock); n++; end
        checks++;
        if (grant_idx_q.size() == gc || grant_idx_q[$] != 0) begin
            errors++; $display("FAIL midrst_first_grant got %0d want 0", (grant_idx_q.size() == gc) ? -1 : grant_idx_q[$]);
        end
        @(posedge Clock); #1;
        req_valid = 4'b0000;
        wait_drain("midrst");
        checks++;
        if (rsp_cnt != rc + 1) begin
            errors++; $display("FAIL midrst_rsp_count got %0d want %0d", rsp_cnt - rc, 1);
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        repeat (2) @(posedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
